pe_conv_sequencer: RTL

- Sequences one PE's 1-D convolution pass once the iact scratchpad fill controller reports the window loaded.
- Generates iact and weight scratchpad read addresses, MAC enable and accumulator clear, and psum write strobes.
- Iterates over filter taps (inner loop) and output positions (outer loop); honours a downstream stall; reports busy/done to the PE top.

---
 rtl/pe_pkg.sv | 16 +
 rtl/cfg_loop_counter.sv | 34 +++
 rtl/pe_conv_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE convolution sequencer: state encoding and default widths.
package pe_pkg;

  localparam int unsigned MAX_CONFIG_WIDTH_DEF = 5;
  localparam int unsigned IACT_ADDR_WIDTH_DEF  = 4;
  localparam int unsigned W_ADDR_WIDTH_DEF     = 4;
  localparam int unsigned PSUM_ADDR_WIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cfg_loop_counter.sv
// Loadable loop counter with clear/increment and an at_last flag against a limit latched on load.
module cfg_loop_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] limit_in,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_last
);

  logic [WIDTH-1:0] limit_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count   <= '0;
      limit_q <= '0;
    end else if (load) begin
      limit_q <= limit_in;
      count   <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  // A zero limit never reaches here while sequencing: the caller traps it before running.
  assign at_last = (count == (limit_q - WIDTH'(1)));

endmodule

// File: rtl/pe_conv_sequencer.sv
// Sequences one PE's 1-D convolution pass: taps inner loop, output positions outer loop.
module pe_conv_sequencer
  import pe_pkg::*;
#(
  parameter int unsigned MAX_CONFIG_WIDTH = MAX_CONFIG_WIDTH_DEF,
  parameter int unsigned IACT_ADDR_WIDTH  = IACT_ADDR_WIDTH_DEF,
  parameter int unsigned W_ADDR_WIDTH     = W_ADDR_WIDTH_DEF,
  parameter int unsigned PSUM_ADDR_WIDTH  = PSUM_ADDR_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [MAX_CONFIG_WIDTH-1:0] filter_size,
  input  logic [MAX_CONFIG_WIDTH-1:0] num_ofmap,
  input  logic                        stall,
  output logic [IACT_ADDR_WIDTH-1:0]  iact_raddr,
  output logic [W_ADDR_WIDTH-1:0]     w_raddr,
  output logic                        mac_en,
  output logic                        acc_clear,
  output logic                        psum_wr,
  output logic [PSUM_ADDR_WIDTH-1:0]  psum_addr,
  output logic                        busy,
  output logic                        done
);

  state_t                      state;
  logic [MAX_CONFIG_WIDTH-1:0] k_cnt;
  logic [MAX_CONFIG_WIDTH-1:0] o_cnt;
  logic                        k_last;
  logic                        o_last;
  logic                        cfg_load;
  logic                        k_inc;
  logic                        next_out;

  assign cfg_load = (state == S_IDLE) && start;
  assign k_inc    = (state == S_RUN) && !stall && !k_last;
  assign next_out = (state == S_WRITE) && !stall && !o_last;

  cfg_loop_counter #(.WIDTH(MAX_CONFIG_WIDTH)) u_tap_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cfg_load),
    .limit_in (filter_size),
    .inc      (k_inc),
    .clr      (next_out),
    .count    (k_cnt),
    .at_last  (k_last)
  );

  cfg_loop_counter #(.WIDTH(MAX_CONFIG_WIDTH)) u_out_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cfg_load),
    .limit_in (num_ofmap),
    .inc      (next_out),
    .clr      (1'b0),
    .count    (o_cnt),
    .at_last  (o_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Empty passes skip straight to the done pulse so the counters never see a zero limit.
            if ((filter_size == '0) || (num_ofmap == '0)) state <= S_DONE;
            else                                          state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!stall && k_last) state <= S_WRITE;
        end
        S_WRITE: begin
          if (!stall) state <= o_last ? S_DONE : S_RUN;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    iact_raddr = '0;
    w_raddr    = '0;
    mac_en     = 1'b0;
    acc_clear  = 1'b0;
    psum_wr    = 1'b0;
    psum_addr  = '0;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    case (state)
      S_RUN: begin
        iact_raddr = IACT_ADDR_WIDTH'({1'b0, o_cnt} + {1'b0, k_cnt});
        w_raddr    = W_ADDR_WIDTH'(k_cnt);
        mac_en     = !stall;
        acc_clear  = (k_cnt == '0) && !stall;
      end
      S_WRITE: begin
        psum_addr = PSUM_ADDR_WIDTH'(o_cnt);
        psum_wr   = !stall;
      end
      default: ;
    endcase
  end

endmodule
